// File: rtl/answer_gen.sv
// answer_gen: builds a DIGITS-digit answer (digits 1..MAX_DIGIT) from a free-running LCG on request.
// Optional macro ANSWER_UNIQUE_EN: reject repeated digits so every answer has distinct digits.
module answer_gen #(
    parameter int          DIGITS    = 8,
    parameter int          DIGIT_W   = 4,
    parameter int          MAX_DIGIT = 8,
    parameter logic [31:0] SEED      = 32'd1,
    parameter logic [31:0] A         = 32'd1103515245,
    parameter logic [31:0] C         = 32'd12345
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      change_answer,
    output logic [DIGITS*DIGIT_W-1:0] answer,
    output logic                      write_enable,
    output logic                      busy
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS*DIGIT_W-1:0] ONES = {DIGITS{DIGIT_W'(1)}};
    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
    state_t                      r_state;
    logic [31:0]                 r_lcg;
    logic                        r_prev;
    logic                        r_pending;
    logic [IW-1:0]               r_idx;
    logic [DIGITS*DIGIT_W-1:0]   r_shadow;
    logic [14:0]                 w_mod;
    logic [DIGIT_W-1:0]          w_cand;
    logic                        w_rise;
    logic                        w_last;
    logic                        w_accept;
    logic                        w_start;
    assign w_mod   = r_lcg[30:16] % 15'(MAX_DIGIT);
    assign w_cand  = DIGIT_W'(w_mod + 15'd1);
    assign w_rise  = change_answer & ~r_prev;
    assign w_last  = r_idx == IW'(DIGITS - 1);
    assign w_start = (r_state == IDLE) && (w_rise || r_pending);
`ifdef ANSWER_UNIQUE_EN
    logic [MAX_DIGIT-1:0] r_used;
    logic [MAX_DIGIT-1:0] w_bit;
    assign w_bit    = MAX_DIGIT'(1) << (w_cand - 1'b1);
    assign w_accept = ~|(r_used & w_bit);
    generate
        if (DIGITS > MAX_DIGIT) begin : g_chk
            $error("answer_gen: unique digits need DIGITS <= MAX_DIGIT");
        end
    endgenerate
    // Digits already placed in the answer under construction; cleared when a new one starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_used <= '0;
        else if (w_start) r_used <= '0;
        else if (r_state == GEN && w_accept) r_used <= r_used | w_bit;
    end
`else
    assign w_accept = 1'b1;
`endif
    // Entropy source: steps every clock, independent of generation activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lcg <= SEED;
        else r_lcg <= A * r_lcg + C;
    end
    // Request edge detect, one-deep request queueing and digit-by-digit answer assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_prev       <= 1'b0;
            r_pending    <= 1'b0;
            r_idx        <= '0;
            r_shadow     <= ONES;
            answer       <= ONES;
            write_enable <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_prev       <= change_answer;
            write_enable <= 1'b0;
            case (r_state)
                IDLE: if (w_start) begin
                    r_state   <= GEN;
                    r_idx     <= '0;
                    r_pending <= 1'b0;
                    busy      <= 1'b1;
                end
                GEN: begin
                    if (w_rise) r_pending <= 1'b1;
                    if (w_accept) begin
                        r_shadow[r_idx*DIGIT_W +: DIGIT_W] <= w_cand;
                        r_idx <= r_idx + 1'b1;
                        if (w_last) r_state <= DONE;
                    end
                end
                DONE: begin
                    if (w_rise) r_pending <= 1'b1;
                    answer       <= r_shadow;
                    write_enable <= 1'b1;
                    busy         <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_answer_gen.sv
// tb_answer_gen: randomized scoreboard bench for answer_gen against an edge-indexed LCG reference.
module tb_answer_gen;
    localparam int D = 8;
    localparam int W = 4;
    localparam int M = 8;
    localparam int HN = 4096;
    localparam logic [D*W-1:0] ONES = 32'h1111_1111;
    typedef struct {
        logic [D*W-1:0] ans;
        int             at;
    } exp_t;
    logic           clk = 0;
    logic           rst_n = 0;
    logic           change_answer = 0;
    logic [D*W-1:0] answer;
    logic           write_enable;
    logic           busy;
    logic [31:0]    hist [0:HN-1];
    exp_t           q [$];
    exp_t           e_m;
    exp_t           e_p;
    int             n = 0;
    int             done = 0;
    bit             active = 0;
    bit             pend = 0;
    bit             prev_ca = 0;
    bit             rise;
    int             errors = 0;
    int             checks = 0;
    int             we_cnt = 0;
    int             base;
    logic [D*W-1:0] last = ONES;
    answer_gen dut (
        .clk(clk), .rst_n(rst_n), .change_answer(change_answer),
        .answer(answer), .write_enable(write_enable), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp_v, n);
        end
    endtask
    // Answer built from the LCG value seen before each digit-writing edge; start = edge the request was taken.
    function automatic void model_gen(input int start, output logic [D*W-1:0] ans, output int fin);
        int m = start;
        int i = 0;
        int d;
`ifdef ANSWER_UNIQUE_EN
        logic [M:1] used = '0;
`endif
        ans = '0;
        while (i < D && m < HN - 1) begin
            d = int'(hist[m][30:16]) % M + 1;
            m++;
`ifdef ANSWER_UNIQUE_EN
            if (!used[d]) begin
                used[d] = 1'b1;
                ans[i*W +: W] = W'(d);
                i++;
            end
`else
            ans[i*W +: W] = W'(d);
            i++;
`endif
        end
        fin = m + 1;
    endfunction
    // Request model: a rise (or a queued request) starts a generation once the previous answer is out.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; active = 0; pend = 0; prev_ca = 0; done = 0;
            q.delete();
        end else begin
            n++;
            rise = change_answer && !prev_ca;
            prev_ca = change_answer;
            if (!active || n > done) begin
                if (pend || rise) begin
                    model_gen(n, e_m.ans, e_m.at);
                    q.push_back(e_m);
                    active = 1; pend = 0; done = e_m.at;
                end
            end else if (rise) pend = 1;
        end
    end
    // Monitor: busy every cycle, answer hold between pulses, scoreboard pop on each write_enable.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) last = ONES;
        else begin
            chk("busy", 32'(busy), 32'(active && n < done));
            if (write_enable) begin
                we_cnt++;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_we: got answer %h expected no pulse (edge %0d)", answer, n);
                end else begin
                    e_p = q.pop_front();
                    chk("answer", answer, e_p.ans);
                    chk("done_edge", n, e_p.at);
                end
                last = answer;
            end else chk("answer_hold", answer, last);
        end
    end
    task automatic cyc(input bit v, input int k);
        repeat (k) begin
            @(negedge clk);
            change_answer = v;
        end
    endtask
    initial begin
        hist[0] = 32'd1;
        for (int i = 1; i < HN; i++) hist[i] = hist[i-1] * 32'd1103515245 + 32'd12345;
        repeat (3) @(negedge clk);
        chk("reset_answer", answer, ONES);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_we", 32'(write_enable), 0);
        rst_n = 1;
        base = we_cnt; cyc(1, 1); cyc(0, 15 + D);
        chk("single_pulses", we_cnt - base, 1);
        base = we_cnt; cyc(1, 30); cyc(0, 15 + D);
        chk("held_pulses", we_cnt - base, 1);
        base = we_cnt; cyc(1, 1); cyc(0, 2); cyc(1, 1); cyc(0, 1); cyc(1, 1); cyc(0, 40 + 2 * D);
        chk("gen_rise_pulses", we_cnt - base, 2);
        repeat (1500) cyc($urandom_range(0, 7) == 0, 1);
        cyc(0, 80);
        chk("queue_drained", q.size(), 0);
        cyc(1, 1); cyc(0, 4);
        #2 rst_n = 0;
        #1;
        chk("midgen_reset_answer", answer, ONES);
        chk("midgen_reset_busy", 32'(busy), 0);
        chk("midgen_reset_we", 32'(write_enable), 0);
        @(negedge clk) rst_n = 1;
        base = we_cnt; cyc(0, 30);
        chk("post_reset_pulses", we_cnt - base, 0);
        chk("post_reset_answer", answer, ONES);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
